gcd_operand_queue: RTL and testbench

- Elastic operand buffer between the test source / request producer and the GCD unit.
- Accepts {A,B} operand pairs on a val/rdy interface, stores up to DEPTH pairs in order, and presents the oldest pair to the GCD unit on a val/rdy interface.
- Decouples producer stalls from GCD iteration latency so back-to-back requests are not lost while the GCD unit is busy.

---
 rtl/gcd_operand_queue_pkg.sv | 24 ++
 rtl/gcd_queue_ptr.sv | 22 ++
 rtl/gcd_operand_queue.sv | 106 ++++++++++
 tb/tb_gcd_operand_queue.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_operand_queue_pkg.sv
// Shared definitions for the GCD datapath and its operand queue: operand width,
// the {A,B} operand pair and a clog2 helper for pointer/count sizing.
package gcd_operand_queue_pkg;

    localparam int OPERAND_W = 16;

    typedef struct packed {
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
    } operand_pair_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gcd_queue_ptr.sv
// Wrapping pointer register with increment enable and synchronous reset;
// wrap-around comes from natural overflow of the W-bit value.
module gcd_queue_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (inc) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/gcd_operand_queue.sv
// Elastic FIFO of {A,B} operand pairs feeding the GCD unit over val/rdy.
// Define GCD_OPERAND_QUEUE_BYPASS_EN for a zero-latency pass-through when empty.
module gcd_operand_queue
    import gcd_operand_queue_pkg::*;
#(
    parameter  int W     = OPERAND_W,
    parameter  int DEPTH = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     in_bits_A,
    input  logic [W-1:0]     in_bits_B,
    input  logic             in_val,
    output logic             in_rdy,
    output logic [W-1:0]     out_bits_A,
    output logic [W-1:0]     out_bits_B,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [W-1:0]     slot_a [DEPTH];
    logic [W-1:0]     slot_b [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             empty;
    logic             enq;
    logic             deq;

    assign empty  = (count == '0);
    assign in_rdy = !reset && (count != FULL_COUNT);

`ifdef GCD_OPERAND_QUEUE_BYPASS_EN
    logic passthru;

    // A pair offered to an empty queue that is taken immediately never touches storage.
    assign passthru = empty && in_val && out_rdy;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        out_val    = 1'b0;
        out_bits_A = slot_a[head];
        out_bits_B = slot_b[head];
        if (!reset) begin
            out_val = empty ? in_val : 1'b1;
        end
        if (empty) begin
            out_bits_A = in_bits_A;
            out_bits_B = in_bits_B;
        end
    end

    assign enq = in_val && in_rdy && !passthru;
    assign deq = out_val && out_rdy && !empty;
`else
    assign out_val    = !reset && !empty;
    assign out_bits_A = slot_a[head];
    assign out_bits_B = slot_b[head];
    assign enq        = in_val && in_rdy;
    assign deq        = out_val && out_rdy;
`endif

    gcd_queue_ptr #(.W(PTR_W)) u_head_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (deq),
        .value (head)
    );

    gcd_queue_ptr #(.W(PTR_W)) u_tail_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (enq),
        .value (tail)
    );

    // NOTE: storage is deliberately not reset; count gates every read, so stale
    // contents are never observed and the array stays plain flops/RAM.
    always_ff @(posedge clk) begin
        if (enq) begin
            slot_a[tail] <= in_bits_A;
            slot_b[tail] <= in_bits_B;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (reset) count <= FULL_COUNT);
    assert property (@(posedge clk) disable iff (reset) !(deq && empty));
    assert property (@(posedge clk) disable iff (reset) !(enq && count == FULL_COUNT));

endmodule

// File: tb/tb_gcd_operand_queue.sv
// Scoreboard bench for gcd_operand_queue: accepted pairs are queued by an input
// tap, a monitor pops and compares at every output transfer.
module tb_gcd_operand_queue;
    import gcd_operand_queue_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [W-1:0]     in_bits_A = '0;
    logic [W-1:0]     in_bits_B = '0;
    logic             in_val = 1'b0;
    logic             in_rdy;
    logic [W-1:0]     out_bits_A;
    logic [W-1:0]     out_bits_B;
    logic             out_val;
    logic             out_rdy = 1'b0;
    logic [CNT_W-1:0] count;

    int checks = 0;
    int errors = 0;

    operand_pair_t sb[$];
    bit            enq_now = 1'b0;
    bit            deq_now = 1'b0;

    gcd_operand_queue #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_bits_A  (in_bits_A),
        .in_bits_B  (in_bits_B),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .out_bits_A (out_bits_A),
        .out_bits_B (out_bits_B),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Input tap: a pair seen with in_val && in_rdy before the edge is accepted at that edge.
    always @(negedge clk) begin
        enq_now = 1'b0;
        if (!reset && in_val && in_rdy) begin
            sb.push_back(operand_pair_t'{a: in_bits_A, b: in_bits_B});
            enq_now = 1'b1;
        end
    end

    // Monitor: compares the head against the oldest outstanding pair and checks occupancy flags.
    always @(negedge clk) begin
        int exp_count;
        #1;
        deq_now = 1'b0;
        if (!reset) begin
            if (out_val) begin
                if (sb.size() == 0) begin
                    check("spurious_out_val", 32'(out_val), 32'd0);
                end else begin
                    check("head_A", 32'(out_bits_A), 32'(sb[0].a));
                    check("head_B", 32'(out_bits_B), 32'(sb[0].b));
                    if (out_rdy) begin
                        void'(sb.pop_front());
                        deq_now = 1'b1;
                    end
                end
            end
            exp_count = int'(sb.size()) - int'(enq_now) + int'(deq_now);
            check("count", 32'(count), 32'(exp_count));
            check("in_rdy", 32'(in_rdy), 32'(exp_count != DEPTH));
`ifdef GCD_OPERAND_QUEUE_BYPASS_EN
            check("out_val", 32'(out_val), 32'((exp_count != 0) || in_val));
`else
            check("out_val", 32'(out_val), 32'(exp_count != 0));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #2;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int budget);
        bit accepted;
        in_bits_A = a;
        in_bits_B = b;
        in_val    = 1'b1;
        for (int i = 0; i < budget; i++) begin
            at_sample();
            accepted = in_rdy;
            step();
            if (accepted) begin
                in_val = 1'b0;
                return;
            end
        end
        at_sample();
        check("send_accept_timeout", 32'(in_rdy), 32'd1);
        step();
        in_val = 1'b0;
    endtask

    task automatic drain();
        in_val  = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 64; i++) begin
            at_sample();
            if (sb.size() == 0) break;
            step();
        end
        check("drain_complete", 32'(sb.size()), 32'd0);
        step();
        out_rdy = 1'b0;
        at_sample();
        check("drain_count", 32'(count), 32'd0);
        check("drain_out_val", 32'(out_val), 32'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset gates both handshakes regardless of the inputs.
        step();
        in_val  = 1'b1;
        out_rdy = 1'b1;
        at_sample();
        check("reset_out_val", 32'(out_val), 32'd0);
        check("reset_in_rdy", 32'(in_rdy), 32'd0);
        step();
        in_val  = 1'b0;
        out_rdy = 1'b0;
        reset   = 1'b0;
        at_sample();
        check("post_reset_count", 32'(count), 32'd0);
        check("post_reset_out_val", 32'(out_val), 32'd0);
        check("post_reset_in_rdy", 32'(in_rdy), 32'd1);
        step();

        // Basic order.
        send(16'd27, 16'd15, 8);
        send(16'd21, 16'd49, 8);
        send(16'd25, 16'd30, 8);
        at_sample();
        check("basic_count", 32'(count), 32'd3);
        step();
        drain();

        // Full: fifth pair held until a dequeue frees a slot.
        send(16'd19, 16'd27, 8);
        send(16'd40, 16'd40, 8);
        send(16'd250, 16'd190, 8);
        send(16'd5, 16'd250, 8);
        at_sample();
        check("full_count", 32'(count), 32'd4);
        check("full_in_rdy", 32'(in_rdy), 32'd0);
        step();
        in_bits_A = 16'd0;
        in_bits_B = 16'd0;
        in_val    = 1'b1;
        out_rdy   = 1'b1;
        at_sample();
        check("full_in_rdy_with_out_rdy", 32'(in_rdy), 32'd0);
        check("full_head_A", 32'(out_bits_A), 32'd19);
        step();
        out_rdy = 1'b0;
        at_sample();
        check("full_after_deq_count", 32'(count), 32'd3);
        check("full_after_deq_in_rdy", 32'(in_rdy), 32'd1);
        step();
        in_val = 1'b0;
        at_sample();
        check("full_refill_count", 32'(count), 32'd4);
        step();
        drain();

        // Simultaneous enqueue and dequeue at count 2.
        send(16'd11, 16'd22, 8);
        send(16'd33, 16'd44, 8);
        at_sample();
        check("simul_pre_count", 32'(count), 32'd2);
        step();
        in_bits_A = 16'd7;
        in_bits_B = 16'd7;
        in_val    = 1'b1;
        out_rdy   = 1'b1;
        step();
        in_val  = 1'b0;
        out_rdy = 1'b0;
        at_sample();
        check("simul_count", 32'(count), 32'd2);
        check("simul_head_A", 32'(out_bits_A), 32'd33);
        step();
        drain();

        // Wrap-around with out_rdy toggling every cycle.
        fork
            begin
                for (int i = 1; i <= 10; i++) send(16'(i), 16'(i + 1), 40);
            end
            begin
                repeat (40) begin
                    step();
                    out_rdy = !out_rdy;
                end
            end
        join
        drain();

        // Reset mid-operation discards queued pairs.
        send(16'd1, 16'd2, 8);
        send(16'd3, 16'd4, 8);
        send(16'd5, 16'd6, 8);
        at_sample();
        check("midreset_pre_count", 32'(count), 32'd3);
        step();
        reset = 1'b1;
        sb.delete();
        at_sample();
        check("midreset_out_val", 32'(out_val), 32'd0);
        check("midreset_in_rdy", 32'(in_rdy), 32'd0);
        step();
        reset = 1'b0;
        at_sample();
        check("midreset_count", 32'(count), 32'd0);
        check("midreset_out_val_after", 32'(out_val), 32'd0);
        step();
        send(16'd5, 16'd250, 8);
        drain();

        // Empty-queue latency.
        in_bits_A = 16'd27;
        in_bits_B = 16'd15;
        in_val    = 1'b1;
        out_rdy   = 1'b1;
        at_sample();
`ifdef GCD_OPERAND_QUEUE_BYPASS_EN
        check("latency_out_val", 32'(out_val), 32'd1);
        check("latency_bits_A", 32'(out_bits_A), 32'd27);
        check("latency_bits_B", 32'(out_bits_B), 32'd15);
`else
        check("latency_out_val", 32'(out_val), 32'd0);
`endif
        step();
        in_val = 1'b0;
        at_sample();
`ifdef GCD_OPERAND_QUEUE_BYPASS_EN
        check("latency_next_count", 32'(count), 32'd0);
        check("latency_next_out_val", 32'(out_val), 32'd0);
`else
        check("latency_next_count", 32'(count), 32'd1);
        check("latency_next_out_val", 32'(out_val), 32'd1);
        check("latency_next_bits_A", 32'(out_bits_A), 32'd27);
`endif
        step();
        drain();

        // Random traffic: a back-pressured phase then a draining phase.
        for (int i = 0; i < 300; i++) begin
            in_val    = 1'($urandom_range(0, 1));
            in_bits_A = 16'($urandom);
            in_bits_B = 16'($urandom);
            out_rdy   = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        check("final_scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
